// File: rtl/buffer_register_gen.sv
// Buffer register (BR) with transfer-register loads, a multi-cycle
// sense window that ORs sense-amplifier outputs into BR and checks
// odd parity, and an LSB-first serial shift-out.
//
// Request/response: SENSE_EN or SHIFT_GO is accepted only in IDLE
// (SENSE_EN wins when both are high). BUSY is high for every cycle of
// the operation. DONE is high for exactly one cycle, the final cycle
// of a completed operation. An aborted shift (CBR) or a reset produces
// no DONE.
module buffer_register_gen #(
    parameter int              WIDTH     = 13,
    parameter int              NMOD      = 4,
    parameter int              SENSE_CYC = 2,
    parameter logic [WIDTH-1:0] ZMASK    = WIDTH'(13'h04B),
    parameter bit              ROTATE    = 1'b0
) (
    input  logic                  V1,
    input  logic                  RST,
    input  logic                  CBR,
    input  logic [NMOD*WIDTH-1:0] SA,
    input  logic                  PAR_IN,
    input  logic [WIDTH-1:0]      TR,
    input  logic                  SBRY,
    input  logic                  SBRZ,
    input  logic                  SENSE_EN,
    input  logic                  SHIFT_GO,
    output logic [WIDTH-1:0]      BR,
    output logic [WIDTH-1:0]      BRN,
    output logic                  SER_OUT,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  PAR_ERR,
    output logic [1:0]            DBG_STATE
);

    // CNT must reach WIDTH-1 (up to 31) or SENSE_CYC-1 (up to 6).
    localparam int CW = 6;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SENSE = 2'd1,
        S_SHIFT = 2'd2
    } state_e;

    // Elaboration-time guard against unsupported parameter values.
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("buffer_register_gen: WIDTH must be 2..32");
    end
    if (NMOD < 1 || NMOD > 8) begin : g_bad_nmod
        $error("buffer_register_gen: NMOD must be 1..8");
    end
    if (SENSE_CYC < 1 || SENSE_CYC > 7) begin : g_bad_sense
        $error("buffer_register_gen: SENSE_CYC must be 1..7");
    end

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] br_q, br_d;
    logic             par_err_q, par_err_d;

    logic [WIDTH-1:0] hold;
    logic [WIDTH-1:0] sa_or;
    logic [WIDTH-1:0] tr_load;
    logic             last_sense;
    logic             last_shift;
    logic             par_set;
    logic             par_clr;
    logic             ser_d;
    logic             done_d;

    // Held contents; CBR kills the feedback path so BR can be rebuilt.
    assign hold = br_q & ~{WIDTH{CBR}};

    // Transfer-register bits selected by the Z mask and its complement.
    assign tr_load = (TR &  ZMASK & {WIDTH{SBRZ}})
                   | (TR & ~ZMASK & {WIDTH{SBRY}});

    assign last_sense = (cnt_q == CW'(SENSE_CYC - 1));
    assign last_shift = (cnt_q == CW'(WIDTH - 1));

    // Wired-OR of every memory module's sense-amplifier group.
    always_comb begin
        sa_or = '0;
        for (int m = 0; m < NMOD; m++) begin
            sa_or = sa_or | SA[m*WIDTH +: WIDTH];
        end
    end

    // Next-state, datapath and output decode for IDLE/SENSE/SHIFT.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        par_set = 1'b0;
        par_clr = 1'b0;
        ser_d   = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                br_d    = hold | tr_load;
                par_clr = CBR;
                if (SENSE_EN) begin
                    state_d = S_SENSE;
                    cnt_d   = '0;
                end else if (SHIFT_GO) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                end
            end

            S_SENSE: begin
                // CBR drops only the held bits; this cycle's SA still lands.
                br_d  = hold | sa_or;
                cnt_d = cnt_q + CW'(1);
                if (last_sense) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    // Odd parity: data bits plus stored bit must XOR to 1.
                    par_set = ((^br_d) == PAR_IN);
                end
            end

            S_SHIFT: begin
                ser_d = br_q[0];
                if (CBR) begin
                    // Abort: register cleared, no completion pulse.
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    br_d    = '0;
                end else begin
                    br_d  = {(ROTATE ? br_q[0] : 1'b0), br_q[WIDTH-1:1]};
                    cnt_d = cnt_q + CW'(1);
                    if (last_shift) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // A parity error raised this cycle wins over a clear.
        par_err_d = par_set | (par_err_q & ~par_clr);
    end

    // State, counter, register and sticky flag with asynchronous reset.
    always_ff @(posedge V1 or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            br_q      <= '0;
            par_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            br_q      <= br_d;
            par_err_q <= par_err_d;
        end
    end

    assign BR        = br_q;
    assign BRN       = ~br_q;
    assign SER_OUT   = ser_d;
    assign BUSY      = (state_q != S_IDLE);
    assign DONE      = done_d;
    assign PAR_ERR   = par_err_q;
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_buffer_register_gen.sv
// Bench for buffer_register_gen: one instance with zero-fill shifting and
// one with rotating shifts, driven by identical stimulus.
module tb_buffer_register_gen;

    localparam int         W  = 13;
    localparam int         NM = 4;
    localparam int         SC = 2;
    localparam logic [W-1:0] ZM = 13'h04B;

    logic            V1, RST, CBR, PAR_IN, SBRY, SBRZ, SENSE_EN, SHIFT_GO;
    logic [NM*W-1:0] SA;
    logic [W-1:0]    TR;

    logic [W-1:0] br0, brn0, br1, brn1;
    logic         ser0, busy0, done0, perr0, ser1, busy1, done1, perr1;
    logic [1:0]   dbg0, dbg1;

    int   n_vec = 0;
    int   n_err = 0;
    logic exp_par = 1'b0;

    buffer_register_gen #(.WIDTH(W), .NMOD(NM), .SENSE_CYC(SC), .ZMASK(ZM), .ROTATE(1'b0)) dut0 (
        .V1(V1), .RST(RST), .CBR(CBR), .SA(SA), .PAR_IN(PAR_IN), .TR(TR),
        .SBRY(SBRY), .SBRZ(SBRZ), .SENSE_EN(SENSE_EN), .SHIFT_GO(SHIFT_GO),
        .BR(br0), .BRN(brn0), .SER_OUT(ser0), .BUSY(busy0), .DONE(done0),
        .PAR_ERR(perr0), .DBG_STATE(dbg0)
    );

    buffer_register_gen #(.WIDTH(W), .NMOD(NM), .SENSE_CYC(SC), .ZMASK(ZM), .ROTATE(1'b1)) dut1 (
        .V1(V1), .RST(RST), .CBR(CBR), .SA(SA), .PAR_IN(PAR_IN), .TR(TR),
        .SBRY(SBRY), .SBRZ(SBRZ), .SENSE_EN(SENSE_EN), .SHIFT_GO(SHIFT_GO),
        .BR(br1), .BRN(brn1), .SER_OUT(ser1), .BUSY(busy1), .DONE(done1),
        .PAR_ERR(perr1), .DBG_STATE(dbg1)
    );

    // Clock
    initial V1 = 1'b0;
    always #5 V1 = ~V1;

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        CBR = 0; SA = '0; PAR_IN = 0; TR = '0;
        SBRY = 0; SBRZ = 0; SENSE_EN = 0; SHIFT_GO = 0;
    endtask

    task automatic next_cycle();
        @(posedge V1);
        #1;
    endtask

    // Clear and load the full TR in one IDLE cycle (also clears PAR_ERR).
    task automatic load_br(input logic [W-1:0] v);
        idle_inputs();
        CBR = 1; SBRY = 1; SBRZ = 1; TR = v;
        next_cycle();
        idle_inputs();
        exp_par = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        RST = 1'b1;
        idle_inputs();
        #2;
        n_vec++; if (br0 !== '0) begin n_err++; $display("FAIL reset_br actual=%h expected=%h", br0, 13'h0); end
        n_vec++; if (brn0 !== 13'h1FFF) begin n_err++; $display("FAIL reset_brn actual=%h expected=%h", brn0, 13'h1FFF); end
        n_vec++; if ({ser0, busy0, done0, perr0} !== 4'b0) begin n_err++; $display("FAIL reset_flags actual=%b expected=0000", {ser0, busy0, done0, perr0}); end
        n_vec++; if (br1 !== '0 || busy1 !== 1'b0) begin n_err++; $display("FAIL reset_rot actual=%h/%b expected=0/0", br1, busy1); end
        n_vec++; if (dbg0 !== 2'd0) begin n_err++; $display("FAIL reset_state actual=%0d expected=0", dbg0); end
        next_cycle();
        RST = 1'b0;
        exp_par = 1'b0;
    endtask

    task automatic test_sense();
        logic [W-1:0]    acc, init, orv;
        logic [NM*W-1:0] sa;
        logic            cbr, pin, last;
        // Randomized windows, with junk on the inputs that SENSE must ignore.
        for (int it = 0; it < 12; it++) begin
            init = W'($urandom) & W'($urandom);
            load_br(init);
            SENSE_EN = 1'b1;
            next_cycle();
            acc = init;
            for (int c = 0; c < SC; c++) begin
                for (int m = 0; m < NM; m++) sa[m*W +: W] = W'($urandom) & W'($urandom) & W'($urandom);
                cbr  = ($urandom_range(0, 3) == 0);
                pin  = 1'($urandom_range(0, 1));
                last = (c == SC - 1);
                SA = sa; CBR = cbr; PAR_IN = pin; TR = W'($urandom);
                SBRY = 1'($urandom_range(0, 1)); SBRZ = 1'($urandom_range(0, 1));
                SENSE_EN = 1'($urandom_range(0, 1)); SHIFT_GO = 1'($urandom_range(0, 1));
                orv = '0;
                for (int m = 0; m < NM; m++) orv = orv | sa[m*W +: W];
                if (cbr) acc = '0;
                acc = acc | orv;
                if (last && ((^acc) == pin)) exp_par = 1'b1;
                @(negedge V1);
                n_vec++; if (busy0 !== 1'b1 || ser0 !== 1'b0 || done0 !== last) begin
                    n_err++; $display("FAIL sense_flags it=%0d c=%0d busy/ser/done actual=%b%b%b expected=10%b", it, c, busy0, ser0, done0, last);
                end
                next_cycle();
            end
            idle_inputs();
            #1;
            n_vec++; if (br0 !== acc || br1 !== acc) begin n_err++; $display("FAIL sense_br it=%0d actual=%h/%h expected=%h", it, br0, br1, acc); end
            n_vec++; if (perr0 !== exp_par || busy0 !== 1'b0) begin n_err++; $display("FAIL sense_par it=%0d perr/busy actual=%b%b expected=%b0", it, perr0, busy0, exp_par); end
        end
        // Directed: 0x0005 from module 0 then 0x1000 from module 3.
        load_br('0);
        for (int rep = 0; rep < 2; rep++) begin
            SENSE_EN = 1'b1;
            next_cycle();
            idle_inputs();
            SA[0 +: W] = 13'h0005; PAR_IN = 1'(rep);
            @(negedge V1);
            n_vec++; if (done0 !== 1'b0) begin n_err++; $display("FAIL sense_dir_done0 rep=%0d actual=%b expected=0", rep, done0); end
            next_cycle();
            SA = '0; SA[3*W +: W] = 13'h1000;
            @(negedge V1);
            n_vec++; if (done0 !== 1'b1) begin n_err++; $display("FAIL sense_dir_done1 rep=%0d actual=%b expected=1", rep, done0); end
            next_cycle();
            idle_inputs();
            exp_par = (rep == 1);
            n_vec++; if (br0 !== 13'h1005) begin n_err++; $display("FAIL sense_dir_br rep=%0d actual=%h expected=1005", rep, br0); end
            n_vec++; if (perr0 !== exp_par) begin n_err++; $display("FAIL sense_dir_par rep=%0d actual=%b expected=%b", rep, perr0, exp_par); end
        end
    endtask

    task automatic test_transfer_load();
        logic [W-1:0] exp_br, tr;
        logic         sy, sz, cbr;
        // Sticky flag survives an IDLE cycle without CBR.
        idle_inputs();
        next_cycle();
        n_vec++; if (perr0 !== 1'b1) begin n_err++; $display("FAIL par_sticky actual=%b expected=1", perr0); end
        CBR = 1'b1;
        next_cycle();
        idle_inputs();
        exp_par = 1'b0;
        n_vec++; if (perr0 !== 1'b0 || br0 !== '0) begin n_err++; $display("FAIL par_clear perr/br actual=%b/%h expected=0/0", perr0, br0); end
        TR = 13'h1FFF; SBRZ = 1'b1;
        next_cycle();
        n_vec++; if (br0 !== 13'h004B) begin n_err++; $display("FAIL load_z actual=%h expected=004B", br0); end
        SBRZ = 1'b0; SBRY = 1'b1;
        next_cycle();
        n_vec++; if (br0 !== 13'h1FFF) begin n_err++; $display("FAIL load_y actual=%h expected=1FFF", br0); end
        idle_inputs(); CBR = 1'b1;
        next_cycle();
        n_vec++; if (br0 !== '0 || brn0 !== 13'h1FFF) begin n_err++; $display("FAIL load_cbr br/brn actual=%h/%h expected=0000/1FFF", br0, brn0); end
        // Random loads: Z-field and Y-field fill independently, CBR wipes first.
        exp_br = '0;
        for (int it = 0; it < 24; it++) begin
            tr = W'($urandom); sy = 1'($urandom_range(0, 1)); sz = 1'($urandom_range(0, 1));
            cbr = ($urandom_range(0, 4) == 0);
            idle_inputs();
            TR = tr; SBRY = sy; SBRZ = sz; CBR = cbr;
            if (cbr) exp_br = '0;
            if (sz) exp_br = exp_br | (tr & ZM);
            if (sy) exp_br = exp_br | (tr & ~ZM);
            next_cycle();
            n_vec++; if (br0 !== exp_br || brn0 !== ~exp_br || br1 !== exp_br) begin
                n_err++; $display("FAIL load_rand it=%0d br/brn actual=%h/%h expected=%h/%h", it, br0, brn0, exp_br, ~exp_br);
            end
        end
        idle_inputs();
    endtask

    task automatic test_shift();
        logic [W-1:0] v, rot;
        for (int it = 0; it < 7; it++) begin
            v = (it == 0) ? 13'h0013 : W'($urandom);
            load_br(v);
            SHIFT_GO = 1'b1;
            next_cycle();
            idle_inputs();
            for (int i = 0; i < W; i++) begin
                rot = (v >> i) | (v << (W - i));
                @(negedge V1);
                n_vec++; if (ser0 !== v[i] || ser1 !== v[i]) begin n_err++; $display("FAIL shift_ser it=%0d i=%0d actual=%b/%b expected=%b", it, i, ser0, ser1, v[i]); end
                n_vec++; if (br0 !== (v >> i) || br1 !== rot) begin n_err++; $display("FAIL shift_br it=%0d i=%0d actual=%h/%h expected=%h/%h", it, i, br0, br1, v >> i, rot); end
                n_vec++; if (done0 !== (i == W - 1) || busy0 !== 1'b1) begin n_err++; $display("FAIL shift_done it=%0d i=%0d done/busy actual=%b%b expected=%b1", it, i, done0, busy0, (i == W - 1)); end
                next_cycle();
            end
            @(negedge V1);
            n_vec++; if (br0 !== '0 || br1 !== v) begin n_err++; $display("FAIL shift_final it=%0d actual=%h/%h expected=0000/%h", it, br0, br1, v); end
            n_vec++; if (busy0 !== 1'b0 || ser0 !== 1'b0 || done0 !== 1'b0) begin n_err++; $display("FAIL shift_idle it=%0d busy/ser/done actual=%b%b%b expected=000", it, busy0, ser0, done0); end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back_request();
        logic [W-1:0] v;
        v = W'($urandom) | 13'h0001;
        load_br(v);
        SENSE_EN = 1'b1; SHIFT_GO = 1'b1;
        next_cycle();
        idle_inputs();
        for (int c = 0; c < SC; c++) begin
            @(negedge V1);
            n_vec++; if (busy0 !== 1'b1 || ser0 !== 1'b0 || done0 !== (c == SC - 1)) begin
                n_err++; $display("FAIL simul c=%0d busy/ser/done actual=%b%b%b expected=10%b", c, busy0, ser0, done0, (c == SC - 1));
            end
            next_cycle();
        end
        n_vec++; if (busy0 !== 1'b0 || br0 !== v) begin n_err++; $display("FAIL simul_end busy/br actual=%b/%h expected=0/%h", busy0, br0, v); end
        exp_par = exp_par | ((^v) == 1'b0);
        n_vec++; if (perr0 !== exp_par) begin n_err++; $display("FAIL simul_par actual=%b expected=%b", perr0, exp_par); end
    endtask

    task automatic test_abort();
        logic [W-1:0] v;
        v = W'($urandom) | 13'h1000;
        load_br(v);
        SHIFT_GO = 1'b1;
        next_cycle();
        idle_inputs();
        for (int i = 0; i <= 4; i++) begin
            CBR = (i == 4);
            @(negedge V1);
            n_vec++; if (done0 !== 1'b0 || busy0 !== 1'b1) begin n_err++; $display("FAIL abort_run i=%0d done/busy actual=%b%b expected=01", i, done0, busy0); end
            next_cycle();
        end
        idle_inputs();
        @(negedge V1);
        n_vec++; if (br0 !== '0 || br1 !== '0) begin n_err++; $display("FAIL abort_br actual=%h/%h expected=0", br0, br1); end
        n_vec++; if (busy0 !== 1'b0 || done0 !== 1'b0 || busy1 !== 1'b0) begin n_err++; $display("FAIL abort_idle busy/done actual=%b%b expected=00", busy0, done0); end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] v, tr;
        // Mid-sense reset.
        load_br(W'($urandom) | 13'h0010);
        SENSE_EN = 1'b1;
        next_cycle();
        idle_inputs();
        SA[W +: W] = W'($urandom) | 13'h0001;
        next_cycle();
        #1;
        RST = 1'b1;
        #1;
        n_vec++; if (br0 !== '0 || brn0 !== 13'h1FFF) begin n_err++; $display("FAIL rst_sense_br br/brn actual=%h/%h expected=0000/1FFF", br0, brn0); end
        n_vec++; if ({ser0, busy0, done0, perr0} !== 4'b0) begin n_err++; $display("FAIL rst_sense_flags actual=%b expected=0000", {ser0, busy0, done0, perr0}); end
        exp_par = 1'b0;
        idle_inputs();
        next_cycle();
        RST = 1'b0;
        @(negedge V1);
        n_vec++; if (done0 !== 1'b0 || busy0 !== 1'b0) begin n_err++; $display("FAIL rst_release done/busy actual=%b%b expected=00", done0, busy0); end
        tr = W'($urandom);
        TR = tr; SBRZ = 1'b1;
        next_cycle();
        idle_inputs();
        n_vec++; if (br0 !== (tr & ZM)) begin n_err++; $display("FAIL rst_first_edge actual=%h expected=%h", br0, tr & ZM); end
        // Mid-shift reset while SER_OUT is high.
        v = W'($urandom) | 13'h0002;
        load_br(v);
        SHIFT_GO = 1'b1;
        next_cycle();
        idle_inputs();
        next_cycle();
        n_vec++; if (ser0 !== 1'b1) begin n_err++; $display("FAIL rst_shift_pre actual=%b expected=1", ser0); end
        RST = 1'b1;
        #1;
        n_vec++; if (ser0 !== 1'b0 || busy0 !== 1'b0 || br0 !== '0 || br1 !== '0) begin
            n_err++; $display("FAIL rst_shift ser/busy/br actual=%b%b/%h expected=00/0000", ser0, busy0, br0);
        end
        next_cycle();
        RST = 1'b0;
        @(negedge V1);
        n_vec++; if (done0 !== 1'b0) begin n_err++; $display("FAIL rst_shift_done actual=%b expected=0", done0); end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_sense();
        test_transfer_load();
        test_shift();
        test_back_to_back_request();
        test_abort();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/buffer_register_gen.md
BUFFER_REGISTER_GEN -- requirements
Module: buffer_register_gen

Interface
REQ-001 Parameter WIDTH, default 13: buffer register width in bits, valid range 2..32.
REQ-002 Parameter NMOD, default 4: number of memory-module sense-amplifier groups, valid range 1..8.
REQ-003 Parameter SENSE_CYC, default 2: number of cycles in the sense window, valid range 1..7.
REQ-004 Parameter ZMASK, default 13'h04B: bits loaded from TR by SBRZ; the Y set is ~ZMASK within WIDTH.
REQ-005 Parameter ROTATE, default 0: 0 = shift fills zeros, 1 = shift rotates BR[0] into BR[WIDTH-1].
REQ-006 Port V1, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-007 Port RST, input, 1 bit: reset, asynchronous, active-high.
REQ-008 Port CBR, input, 1 bit: clear buffer register (inhibits hold feedback).
REQ-009 Port SA, input, NMOD*WIDTH bits: sense-amp outputs; module m occupies SA[m*WIDTH +: WIDTH].
REQ-010 Port PAR_IN, input, 1 bit: stored odd-parity bit for the word being sensed.
REQ-011 Port TR, input, WIDTH bits: transfer register contents.
REQ-012 Port SBRY, input, 1 bit: load TR bits selected by the Y mask.
REQ-013 Port SBRZ, input, 1 bit: load TR bits selected by ZMASK.
REQ-014 Port SENSE_EN, input, 1 bit: start a sense window.
REQ-015 Port SHIFT_GO, input, 1 bit: start a serial shift-out.
REQ-016 Port BR, output, WIDTH bits: register contents.
REQ-017 Port BRN, output, WIDTH bits: bitwise complement of BR.
REQ-018 Port SER_OUT, output, 1 bit: serial data, LSB first.
REQ-019 Port BUSY, output, 1 bit: high when the FSM is not in IDLE.
REQ-020 Port DONE, output, 1 bit: one-cycle pulse at the end of a sense window or a shift.
REQ-021 Port PAR_ERR, output, 1 bit: sticky parity error flag.

Function
REQ-022 The FSM SHALL have three states: IDLE, SENSE, SHIFT; a counter CNT SHALL track cycles within SENSE and SHIFT.
REQ-023 hold SHALL be BR & ~{WIDTH{CBR}}.
REQ-024 In IDLE, next BR SHALL be hold | (TR & ZMASK & {WIDTH{SBRZ}}) | (TR & ~ZMASK & {WIDTH{SBRY}}); SBRY and SBRZ together SHALL load the full TR.
REQ-025 IDLE with SENSE_EN=1 SHALL go to SENSE with CNT=0; SENSE_EN SHALL take priority over a simultaneous SHIFT_GO, which is ignored.
REQ-026 IDLE with SHIFT_GO=1 and SENSE_EN=0 SHALL go to SHIFT with CNT=0.
REQ-027 In SENSE, each cycle next BR SHALL be hold | OR over m of SA module m; CNT SHALL increment.
REQ-028 In SENSE, SBRY, SBRZ, SENSE_EN and SHIFT_GO SHALL be ignored.
REQ-029 On the SENSE cycle with CNT=SENSE_CYC-1, the FSM SHALL return to IDLE and pulse DONE.
REQ-030 On that same cycle, PAR_ERR SHALL be set if XOR-reduce(next BR) ^ PAR_IN = 0 (odd parity violated).
REQ-031 In SHIFT, SER_OUT SHALL equal BR[0]; BR SHALL shift right with MSB = ROTATE ? BR[0] : 0; CNT SHALL increment.
REQ-032 SHIFT SHALL end after exactly WIDTH cycles (CNT=WIDTH-1), then return to IDLE and pulse DONE.
REQ-033 When ROTATE=1, BR after a completed shift SHALL equal BR before the shift.
REQ-034 SER_OUT SHALL be 0 outside SHIFT.
REQ-035 CBR in SENSE SHALL clear only the held contents; SA bits of that cycle SHALL still be ORed in, and the window SHALL continue.
REQ-036 CBR in SHIFT SHALL abort: next cycle BR=0, state IDLE, and no DONE pulse.
REQ-037 PAR_ERR SHALL clear only on CBR asserted in IDLE, or on RST; a same-cycle parity error SHALL take priority over the clear.
REQ-038 BRN SHALL always equal ~BR combinationally.

Reset
REQ-039 While RST=1, asynchronously: BR=0, BRN=all ones, state IDLE, CNT=0, SER_OUT=0, BUSY=0, DONE=0, PAR_ERR=0.
REQ-040 RST asserted mid-SENSE or mid-SHIFT SHALL abandon the operation with no DONE pulse; the first edge after RST deasserts SHALL evaluate from IDLE.

Verification (defaults)
REQ-041 Sense/parity scenario: SENSE_EN with module0 SA=13'h0005 in cycle 0, module3 SA=13'h1000 in cycle 1, PAR_IN=0 -> BR=13'h1005, DONE in cycle 1, PAR_ERR=0; repeat with PAR_IN=1 -> PAR_ERR=1.
REQ-042 Transfer-load scenario: from BR=0, TR=13'h1FFF with SBRZ only -> BR=13'h004B; then SBRY only -> BR=13'h1FFF; then CBR -> BR=0.
REQ-043 Shift scenario: BR=13'h0013, SHIFT_GO -> SER_OUT sequence 1,1,0,0,1, then 8 zeros; DONE on the 13th cycle; final BR=0 (ROTATE=0) or 13'h0013 (ROTATE=1).
REQ-044 Simultaneous-request scenario: SENSE_EN and SHIFT_GO in the same IDLE cycle -> SENSE entered, SER_OUT stays 0, BUSY for 2 cycles.
REQ-045 Abort scenario: CBR on shift cycle 4 -> IDLE, BR=0, no DONE.
REQ-046 Reset scenario: RST mid-sense -> all outputs reach reset values without a clock edge.
